// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues reads to a synchronous program
// ROM, buffers returned words with their addresses in a small prefetch FIFO
// and presents them to the decoder over a valid/ready handshake. A redirect
// flushes buffered and in-flight words and restarts fetch at a new address.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        prom_addr,
    output logic                     prom_en,
    input  logic [INSTR_W-1:0]       prom_data,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_addr,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [ADDR_W-1:0]  pc;
    logic               inflight;
    logic [ADDR_W-1:0]  tag;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [LW-1:0]      count;

    logic [INSTR_W-1:0] word_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];

    logic               pop;
    logic               push;
    logic               issue;
    logic [LW:0]        occupancy;

    // Handshake, push and issue decisions; the occupancy counts the word in
    // flight so a returning word always has a free slot waiting for it.
    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        issue     = 1'b0;
        occupancy = '0;
        pop       = (count != '0) && instr_ready;
        push      = inflight && !redirect && !rst;
        occupancy = {1'b0, count} + (LW+1)'(inflight) - (LW+1)'(pop);
        issue     = !rst && !redirect && (occupancy < (LW+1)'(DEPTH));
    end

    assign prom_addr   = pc;
    assign prom_en     = issue;
    assign instr_valid = (count != '0);
    assign instr       = word_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign fifo_level  = count;

    // PC, in-flight tracking and FIFO pointers; redirect flushes everything
    // except the new PC, and reset has priority over redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            tag      <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            pc       <= redirect_addr;
            inflight <= 1'b0;
            tag      <= pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc <= pc + ADDR_W'(1);
            end
            inflight <= issue;
            tag      <= pc;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage is left unreset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= prom_data;
            pc_mem[wr_ptr]   <= tag;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, reset
// mid-stream and PC wrap, against a ROM returning {16'hC0DE, address}.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_addr;

    logic [15:0] prom_addr;
    logic        prom_en;
    logic [31:0] prom_data;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic [2:0]  fifo_level;

    logic [15:0] w_prom_addr;
    logic        w_prom_en;
    logic [31:0] w_prom_data;
    logic [31:0] w_instr;
    logic [15:0] w_instr_pc;
    logic        w_instr_valid;
    logic [2:0]  w_fifo_level;

    int          checks;
    int          failures;
    logic [15:0] exp_pc;
    logic [15:0] exp_fetch;
    logic [15:0] wrap_exp [4];
    logic        en_q;
    logic        w_en_q;

    fetch_unit #(.ADDR_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .prom_addr(prom_addr), .prom_en(prom_en), .prom_data(prom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .fifo_level(fifo_level)
    );

    fetch_unit #(.ADDR_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst),
        .prom_addr(w_prom_addr), .prom_en(w_prom_en), .prom_data(w_prom_data),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .fifo_level(w_fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: word valid one cycle after the address.
    always @(posedge clk) begin
        prom_data   <= {16'hC0DE, prom_addr};
        w_prom_data <= {16'hC0DE, w_prom_addr};
        en_q        <= prom_en;
        w_en_q      <= w_prom_en;
    end

    // A push into a full FIFO without a simultaneous pop must never happen.
    always @(posedge clk) begin
        assert (!(en_q && !redirect && !rst && !(instr_valid && instr_ready) && fifo_level == 3'd4))
        else begin
            failures++;
            $display("FAIL overflow dut: push into full fifo level=%0d", fifo_level);
        end
        assert (!(w_en_q && !redirect && !rst && !(w_instr_valid && instr_ready) && w_fifo_level == 3'd4))
        else begin
            failures++;
            $display("FAIL overflow dut_w: push into full fifo level=%0d", w_fifo_level);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (prom_addr !== 16'h0000) begin failures++; $display("FAIL reset_prom_addr got=%h exp=0000", prom_addr); end
        checks++; if (prom_en !== 1'b0) begin failures++; $display("FAIL reset_prom_en got=%b exp=0", prom_en); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (w_prom_addr !== 16'hFFFE) begin failures++; $display("FAIL reset_w_prom_addr got=%h exp=fffe", w_prom_addr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        rst = 1'b0; instr_ready = 1'b1;
        #1;
        checks++; if (prom_en !== 1'b1 || prom_addr !== 16'h0000) begin failures++; $display("FAIL stream_first_issue got en=%b addr=%h exp en=1 addr=0000", prom_en, prom_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_c0 got=%b exp=0", instr_valid); end
        adv();
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_c1 got=%b exp=0", instr_valid); end
        adv();
        exp_pc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid got=%b exp=1 cycle=%0d", instr_valid, i); end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== {16'hC0DE, exp_pc}) begin
                    failures++; $display("FAIL stream_word got pc=%h instr=%h exp pc=%h", instr_pc, instr, exp_pc);
                end
                exp_pc = exp_pc + 16'd1;
            end
            adv();
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            instr_ready = 1'b0;
            #1;
            if (fifo_level == 3'd4) begin
                checks++; if (prom_en !== 1'b0) begin failures++; $display("FAIL bp_issue_stop got=%b exp=0 cycle=%0d", prom_en, i); end
            end
            adv();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i == 0) begin
                checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
                checks++; if (prom_en !== 1'b1) begin failures++; $display("FAIL bp_resume got=%b exp=1", prom_en); end
            end
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_gap got=%b exp=1 cycle=%0d", instr_valid, i); end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== {16'hC0DE, exp_pc}) begin
                    failures++; $display("FAIL bp_word got pc=%h instr=%h exp pc=%h", instr_pc, instr, exp_pc);
                end
                exp_pc = exp_pc + 16'd1;
            end
            adv();
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        #1;
        checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL mrst_pre_level got=%0d exp=3", fifo_level); end
        checks++; if (prom_en !== 1'b0) begin failures++; $display("FAIL mrst_en_in_rst got=%b exp=0", prom_en); end
        adv();
        rst = 1'b0;
        #1;
        checks++; if (fifo_level !== 3'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mrst_cleared got level=%0d valid=%b exp level=0 valid=0", fifo_level, instr_valid); end
        checks++; if (prom_addr !== 16'h0000 || prom_en !== 1'b1) begin failures++; $display("FAIL mrst_restart got addr=%h en=%b exp addr=0000 en=1", prom_addr, prom_en); end
        adv();
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mrst_stale got valid=%b pc=%h exp valid=0", instr_valid, instr_pc); end
        adv();
        exp_pc = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL mrst_valid got=%b exp=1 cycle=%0d", instr_valid, i); end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== {16'hC0DE, exp_pc}) begin
                    failures++; $display("FAIL mrst_word got pc=%h instr=%h exp pc=%h", instr_pc, instr, exp_pc);
                end
                exp_pc = exp_pc + 16'd1;
            end
            adv();
        end
    endtask

    task automatic test_redirect_inflight();
        instr_ready = 1'b0;
        #1;
        adv();
        redirect = 1'b1; redirect_addr = 16'h0100;
        #1;
        checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL rdi_pre_level got=%0d exp=2", fifo_level); end
        checks++; if (prom_en !== 1'b0) begin failures++; $display("FAIL rdi_no_issue got=%b exp=0", prom_en); end
        adv();
        redirect = 1'b0; instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL rdi_flush got valid=%b level=%0d exp valid=0 level=0", instr_valid, fifo_level); end
        checks++; if (prom_addr !== 16'h0100 || prom_en !== 1'b1) begin failures++; $display("FAIL rdi_target_issue got addr=%h en=%b exp addr=0100 en=1", prom_addr, prom_en); end
        adv();
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdi_stale got valid=%b pc=%h exp valid=0", instr_valid, instr_pc); end
        adv();
        exp_pc = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL rdi_valid got=%b exp=1 cycle=%0d", instr_valid, i); end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== {16'hC0DE, exp_pc}) begin
                    failures++; $display("FAIL rdi_word got pc=%h instr=%h exp pc=%h", instr_pc, instr, exp_pc);
                end
                exp_pc = exp_pc + 16'd1;
            end
            adv();
        end
    endtask

    task automatic test_redirect_pop_b2b();
        redirect = 1'b1; redirect_addr = 16'h0010; instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin failures++; $display("FAIL rdp_consumed got valid=%b pc=%h exp valid=1 pc=%h", instr_valid, instr_pc, exp_pc); end
        checks++; if (prom_en !== 1'b0) begin failures++; $display("FAIL rdp_no_issue1 got=%b exp=0", prom_en); end
        adv();
        redirect_addr = 16'h0020;
        #1;
        checks++; if (instr_valid !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL rdp_flush got valid=%b level=%0d exp valid=0 level=0", instr_valid, fifo_level); end
        checks++; if (prom_en !== 1'b0) begin failures++; $display("FAIL rdp_no_issue2 got=%b exp=0", prom_en); end
        adv();
        redirect = 1'b0;
        exp_pc = 16'h0020;
        exp_fetch = 16'h0020;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i == 0) begin
                checks++; if (prom_en !== 1'b1) begin failures++; $display("FAIL rdp_issue got=%b exp=1", prom_en); end
            end
            if (prom_en) begin
                checks++;
                if (prom_addr !== exp_fetch) begin failures++; $display("FAIL rdp_fetch_addr got=%h exp=%h", prom_addr, exp_fetch); end
                exp_fetch = exp_fetch + 16'd1;
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== {16'hC0DE, exp_pc}) begin
                    failures++; $display("FAIL rdp_word got pc=%h instr=%h exp pc=%h", instr_pc, instr, exp_pc);
                end
                exp_pc = exp_pc + 16'd1;
            end
            adv();
        end
        checks++; if (exp_pc !== 16'h0026) begin failures++; $display("FAIL rdp_handshakes got next_pc=%h exp=0026", exp_pc); end
    endtask

    task automatic test_wrap();
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
        rst = 1'b1; instr_ready = 1'b1;
        adv();
        rst = 1'b0;
        adv();
        adv();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (w_instr_valid !== 1'b1 || w_instr_pc !== wrap_exp[i] || w_instr !== {16'hC0DE, wrap_exp[i]}) begin
                failures++; $display("FAIL wrap_seq got valid=%b pc=%h instr=%h exp pc=%h", w_instr_valid, w_instr_pc, w_instr, wrap_exp[i]);
            end
            adv();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_mid_reset();
        test_redirect_inflight();
        test_redirect_pop_b2b();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit sitting between the program ROM and `cpu`, replacing direct single-instruction presentation on `instruction`/`prom_addr`. It owns the program counter, issues addresses to a synchronous program ROM, buffers returned words in a prefetch FIFO, and hands them to the decoder over a valid/ready handshake. It also supports redirects for branches and jumps, which flush any prefetched work.

## Interface
- `ADDR_W`, 16, program counter and ROM address width.
- `INSTR_W`, 32, instruction word width.
- `DEPTH`, 4, prefetch FIFO entries; power of two, minimum 2.
- `RESET_PC`, 0, PC value loaded on reset; `ADDR_W` bits.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `prom_addr` out `ADDR_W`: ROM read address; always equals the PC register.
- `prom_en` out 1: a fetch is issued this cycle.
- `prom_data` in `INSTR_W`: ROM word; valid exactly one cycle after the `prom_en`/`prom_addr` cycle.
- `instr` out `INSTR_W`: instruction word at the FIFO head.
- `instr_pc` out `ADDR_W`: address of `instr`.
- `instr_valid` out 1: the FIFO head is valid.
- `instr_ready` in 1: the consumer accepts the head this cycle.
- `redirect` in 1: flush the pipeline and load a new PC.
- `redirect_addr` in `ADDR_W`: target PC, sampled when `redirect` is high.
- `fifo_level` out `$clog2(DEPTH)+1`: number of FIFO entries.

## Operation
- State:
  - PC register.
  - In-flight flag plus in-flight tag (the issued address).
  - FIFO of {word, pc} pairs with read/write pointers and a count.
- pop = `instr_valid` && `instr_ready`.
- Issue condition: !`rst` && !`redirect` && (count + inflight − pop) < `DEPTH`.
  - On issue: `prom_en`=1, and PC <= PC+1, wrapping modulo 2^`ADDR_W` (all-ones becomes 0).
  - The in-flight flag is set to the issue value every cycle, and the tag is set to PC.
- Return cycle (in-flight flag set):
  - Push {`prom_data`, tag} into the FIFO, unless `redirect` is high that cycle, in which case the word is discarded.
  - Overflow is impossible by construction. A push that would overflow is a design bug and must be assertion-checked in the bench.
- Pop: advance the read pointer. Push and pop in the same cycle leave count unchanged.
- `redirect` cycle:
  - Count, pointers and the in-flight flag are cleared.
  - PC <= `redirect_addr`. No issue happens that cycle.
  - A handshake completing in the same cycle is still consumed by the consumer; the flush takes precedence for internal state.
  - If `redirect` is held for multiple cycles, the last `redirect_addr` wins and nothing is issued while it is held.
- `instr_valid` = (count != 0). `instr`/`instr_pc` are driven from the head entry and are meaningful only while `instr_valid` is high.
- FIFO storage is not reset.

## Timing
- Reset values, one cycle after `rst` is sampled high:
  - `prom_addr`=`RESET_PC`.
  - `prom_en`=0 while `rst` is high.
  - `instr_valid`=0 and `fifo_level`=0.
  - In-flight flag cleared.
  - `instr`/`instr_pc` are don't-care.
- Reset mid-operation: identical result. Buffered and in-flight words are dropped, and a ROM word returning in the cycle after reset is ignored.
- Start-up: first issue in the first cycle with `rst` low. `instr_valid` rises 2 cycles later (issue → ROM return → FIFO head).
- Redirect latency: `redirect` in cycle t → issue of the target in t+1 → `instr_valid` with `instr_pc`=target in t+3.
- Throughput: one instruction per cycle while `instr_ready` is held high, for any `DEPTH` ≥ 2.
- Backpressure:
  - Issue stops once count + inflight reaches `DEPTH`.
  - After `instr_ready` returns high, issue resumes in the same cycle as the first pop.
  - No word is lost or reordered.
- `instr`, `instr_pc`, `instr_valid` and `fifo_level` are combinational from registers only; none depend combinationally on `instr_ready` or `redirect`.
- `prom_en` depends combinationally on `instr_ready`, `redirect` and `rst`.

## Test plan
- Reset and stream:
  - Stimulus: ROM model mem[a]={16'hC0DE, a}, `RESET_PC`=0, ready high.
  - Required: `instr_valid` first high 2 cycles after reset release, then one handshake per cycle with `instr_pc`=0,1,2,… and `instr`=32'hC0DE0000, 32'hC0DE0001, ….
- Backpressure:
  - Stimulus: ready low for 10 cycles mid-stream, `DEPTH`=4.
  - Required: `prom_en` low once the level reaches 4, `fifo_level` holds at 4, and the sequence continues gap-free and in order after ready returns.
- Redirect with a word in flight:
  - Stimulus: `redirect`=1 with `redirect_addr`=16'h0100 while a fetch is in flight and the FIFO holds 2 entries.
  - Required: `instr_valid`=0 the next cycle, `prom_addr`=16'h0100 with `prom_en`=1 in t+1, and the next valid `instr_pc`=16'h0100 in t+3. No stale words appear.
- Wrap:
  - Stimulus: `RESET_PC`=16'hFFFE.
  - Required: `instr_pc` sequence FFFE, FFFF, 0000, 0001.
- Reset mid-stream:
  - Stimulus: `rst` pulsed for 1 cycle with the FIFO level at 3 and a fetch in flight.
  - Required: next cycle `fifo_level`=0 and `instr_valid`=0; the stream restarts from `RESET_PC` with the 2-cycle start-up latency.
- Redirect coinciding with a pop, and with back-to-back redirects:
  - Stimulus: `redirect` in the same cycle as a handshake, and a redirect on 2 consecutive cycles to 0x0010 then 0x0020.
  - Required: the FIFO is empty afterwards, and only 0x0020 and its successors are fetched.
